rain_irrigation_ctrl: RTL
=========================

Name: rain_irrigation_ctrl

Overview:
Sequencing controller for the field rain-alert and irrigation outputs. It synchronises and debounces the raw rain sensor, drives the alert LED and a timed buzzer pulse, and arbitrates the irrigation valve between operator requests and rain lockout. The irrigation valve follows a max-run limit and a post-rain hold-off.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable synchronised samples before rain_det changes (>=1)
BUZZ_CYC, 8, buzzer pulse length in clk cycles per rain onset (>=1)
HOLDOFF_CYC, 16, dry cycles required after rain clears before irrigation may resume (>=1)
IRR_MAX_CYC, 32, maximum continuous irrigation run in cycles (>=1)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  asynchronous active-low reset
rain_sensor  in  1  raw rain sensor level, asynchronous to clk; 1 = rain
irr_req  in  1  operator/timer irrigation request, synchronous level
led  out  1  rain indicator, equals rain_det
buzzer  out  1  alert pulse on each debounced rain onset
irrigation_switch  out  1  valve drive; 1 = irrigating
busy_state  out  2  current FSM state encoding, for status readout
rain_events  out  8  saturating debounced-rain-onset count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): sync flops=0, rain_det=0, led=0, buzzer=0, irrigation_switch=0, state=IDLE (2'd0), all counters=0, rain_events=0.
- Synchroniser: rain_sensor passes through a 2-flop synchroniser to give rain_s.
- Debounce: the counter increments while rain_s != rain_det and clears when they are equal. When the count reaches DEBOUNCE_CYC-1 and rain_s still differs, rain_det toggles and the counter clears. Glitches shorter than DEBOUNCE_CYC cycles never change rain_det. Total latency from a stable raw change to rain_det is DEBOUNCE_CYC+2 cycles.
- led: registered copy of rain_det, updated on the same edge as rain_det.
- Buzzer: on the rain_det 0->1 edge, buzzer=1 for exactly BUZZ_CYC cycles, starting the cycle after rain_det rises.
  - A new onset while the buzzer is active reloads the timer. This needs rain to clear and return through debounce.
  - Rain clearing does not cut the pulse short.
- FSM states: IDLE=0, IRRIGATE=1, RAIN_HOLD=2, DONE=3.
  - IDLE -> IRRIGATE: irr_req=1 and rain_det=0. The run counter loads 0.
  - IRRIGATE -> IDLE: irr_req=0.
  - IRRIGATE -> DONE: run counter reaches IRR_MAX_CYC-1, i.e. exactly IRR_MAX_CYC cycles with the valve on.
  - DONE -> IDLE: irr_req=0. Re-arming requires the request to drop.
  - Any state -> RAIN_HOLD: rain_det=1. This has priority over every other transition. The hold counter clears.
  - RAIN_HOLD: the hold counter clears every cycle rain_det=1 and increments while rain_det=0. Exit to IDLE when the count reaches HOLDOFF_CYC-1 with rain_det=0.
- irrigation_switch: registered, equal to (next_state==IRRIGATE), so it changes on the same edge as state. The valve drops on the edge after rain_det rises.
- Simultaneous events:
  - rain_det rising in the same cycle irr_req rises: go to RAIN_HOLD, the valve never opens.
  - Run-limit expiry in the same cycle as a rain onset: go to RAIN_HOLD.
- Mid-operation reset: all outputs drop immediately (asynchronously). The block restarts in IDLE with no buzzer pulse pending.
- Counter widths: $clog2(X+1) bits for each parameter X. Counters never wrap. rain_events saturates at 255.

Optional Feature:
RAIN_EVENT_COUNT_EN: when defined, rain_events increments by 1 on each rain_det 0->1 edge, saturating at 8'hFF, and is cleared only by reset. When undefined, rain_events is tied to 8'h00 and no counter logic is synthesised. The port list is unchanged either way.

Decomposition:
- Package rain_ctrl_pkg:
  - state typedef: IDLE, IRRIGATE, RAIN_HOLD, DONE as 2-bit enum
  - RAIN_EVT_W = 8
  - count-width helper constants
- Sub-module rain_debounce (params DEBOUNCE_CYC; ports clk, rst_n, raw_in, level_out, rise_pulse) holds the synchroniser and debounce counter. The top keeps the FSM, buzzer timer, and event counter.

Test Plan:
- Glitch reject: with DEBOUNCE_CYC=4, pulse rain_sensor high for 3 cycles -> rain_det, led, and buzzer stay 0, and busy_state stays unchanged.
- Rain onset: hold rain_sensor=1 -> led=1 at 6 cycles; buzzer=1 for exactly 8 cycles starting 7 cycles after the change; rain_events=1 with the macro defined.
- Run limit: irr_req=1 and dry -> irrigation_switch=1 for exactly 32 cycles, then state=DONE and switch=0. Hold irr_req=1 -> stays DONE. Drop irr_req -> IDLE.
- Rain during irrigation: rain_det rises at cycle 10 of the run -> switch=0 on the next edge, state=RAIN_HOLD.
- Hold-off restart: after the rain clears, re-assert rain for 5 cycles (debounced) -> hold counter restarts. Resume happens only after 16 consecutive dry rain_det cycles, then IRRIGATE if irr_req=1.
- Async reset: assert rst_n=0 mid-buzzer while IRRIGATE -> all outputs 0 immediately. After release, state=IDLE and buzzer=0.

Source files
------------

// File: rtl/rain_ctrl_pkg.sv
// Shared state encoding and width helpers for the rain alert / irrigation controller.
package rain_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IRRIGATE  = 2'd1,
      RAIN_HOLD = 2'd2,
      DONE      = 2'd3
   } state_e;

   localparam int RAIN_EVT_W = 8;

   function automatic int cnt_w(input int x);
      return $clog2(x + 1);
   endfunction

endpackage

// File: rtl/rain_debounce.sv
// Two-flop synchroniser plus stability debounce for the raw rain sensor.
// rise_pulse is high for the one cycle after level_out goes 0->1.
module rain_debounce
   import rain_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse
);

   localparam int CW = cnt_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYC - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          rise_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == TC) begin
            // disagreement has held for DEBOUNCE_CYC samples: accept the new level
            cnt_q   <= '0;
            level_q <= sync2_q;
            rise_q  <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/rain_irrigation_ctrl.sv
// Rain alert (LED + buzzer pulse) and irrigation valve sequencer with rain lockout.
// Define RAIN_EVENT_COUNT_EN to build the saturating rain-onset counter on rain_events.
//
// state     | meaning
// IDLE      | valve closed, waiting for irr_req while dry
// IRRIGATE  | valve open, run timer counting down
// RAIN_HOLD | rain present or recently cleared; waiting out the dry hold-off
// DONE      | run limit reached; waiting for irr_req to drop before re-arming
module rain_irrigation_ctrl
   import rain_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int BUZZ_CYC     = 8,
   parameter int HOLDOFF_CYC  = 16,
   parameter int IRR_MAX_CYC  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rain_sensor,
   input  logic                  irr_req,
   output logic                  led,
   output logic                  buzzer,
   output logic                  irrigation_switch,
   output logic [1:0]            busy_state,
   output logic [RAIN_EVT_W-1:0] rain_events
);

   localparam int BW = cnt_w(BUZZ_CYC);
   localparam int HW = cnt_w(HOLDOFF_CYC);
   localparam int RW = cnt_w(IRR_MAX_CYC);
   localparam logic [BW-1:0] BUZZ_LD = BW'(BUZZ_CYC);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF_CYC - 1);
   localparam logic [RW-1:0] RUN_LD  = RW'(IRR_MAX_CYC - 1);

   logic          rain_det;
   logic          rain_rise;
   state_e        state_q;
   logic [HW-1:0] hold_q;
   logic [RW-1:0] run_q;
   logic          valve_q;
   logic [BW-1:0] buzz_q, buzz_d;
   logic          buzzer_q;

   rain_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (rain_sensor),
      .level_out  (rain_det),
      .rise_pulse (rain_rise)
   );

   // A new onset reloads the pulse; rain clearing never shortens it.
   always_comb begin
      buzz_d = buzz_q;
      if (rain_rise) begin
         buzz_d = BUZZ_LD;
      end else if (buzz_q != '0) begin
         buzz_d = buzz_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buzz_q   <= '0;
         buzzer_q <= 1'b0;
      end else begin
         buzz_q   <= buzz_d;
         buzzer_q <= (buzz_d != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         run_q   <= '0;
         valve_q <= 1'b0;
      end else if (rain_det) begin
         state_q <= RAIN_HOLD;
         hold_q  <= HOLD_LD;
         valve_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (irr_req) begin
                  state_q <= IRRIGATE;
                  run_q   <= RUN_LD;
                  valve_q <= 1'b1;
               end
            end
            IRRIGATE: begin
               if (!irr_req) begin
                  state_q <= IDLE;
                  valve_q <= 1'b0;
               end else if (run_q == '0) begin
                  state_q <= DONE;
                  valve_q <= 1'b0;
               end else begin
                  run_q <= run_q - 1'b1;
               end
            end
            RAIN_HOLD: begin
               if (hold_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            default: begin
               if (!irr_req) begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef RAIN_EVENT_COUNT_EN
   logic [RAIN_EVT_W-1:0] evt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q <= '0;
      end else if (rain_rise && (evt_q != '1)) begin
         evt_q <= evt_q + 1'b1;
      end
   end

   assign rain_events = evt_q;
`else
   assign rain_events = '0;
`endif

   assign led               = rain_det;
   assign buzzer            = buzzer_q;
   assign irrigation_switch = valve_q;
   assign busy_state        = state_q;

endmodule
